mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the CPU's single 64-bit memory port. Requester 0 is instruction fetch, requester 1 is data load/store. The block serialises their transactions onto the shared read/write strobe + `i_mem_valid` bus and forwards paging faults. It adds a watchdog timeout so a silent memory cannot hang the core.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer for the 64-bit memory port.
// Requester 0 is instruction fetch and requester 1 is data load/store.
// Each granted transaction is driven onto the read/write strobes until it
// completes. A transaction completes on i_mem_valid, on a paging fault, or
// when the watchdog expires.
// Ports: i_clk/i_rst_n (async active-low); per-requester i_reqN/i_weN/i_addrN/
//   i_wdataN in and o_gntN/o_doneN pulses out; shared o_err/o_rdata/o_busy;
//   memory side o_mem_address/o_mem_read/o_mem_write/o_mem_data and
//   i_mem_data/i_mem_valid/i_error_not_present/i_error_not_user.
// Config: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking. If it is
//   not defined, requester 1 has fixed priority.
// Param: TIMEOUT = BUSY cycles before abort with err 3 (0 disables watchdog).
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [63:0] i_wdata0,
  input  logic [63:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [1:0]  o_err,
  output logic [63:0] o_rdata,
  output logic        o_busy,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [63:0] o_mem_data,
  input  logic [63:0] i_mem_data,
  input  logic        i_mem_valid,
  input  logic        i_error_not_present,
  input  logic        i_error_not_user
);

  localparam int unsigned CLOG = $clog2(TIMEOUT + 1);
  localparam int unsigned CW   = (CLOG > 8) ? CLOG : 8;
  localparam bit          WD_EN = (TIMEOUT != 0);
  // Count value seen at the edge that expires the watchdog.
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic [31:0]   addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          win;
  logic          fin;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = err_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    fin     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
    // On a tie the requester not granted last time wins.
    win     = (i_req0 && i_req1) ? ~last_q : i_req1;
`else
    win     = i_req1;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          owner_d = win;
          addr_d  = win ? i_addr1 : i_addr0;
          wdata_d = win ? i_wdata1 : i_wdata0;
          rd_d    = win ? ~i_we1 : ~i_we0;
          wr_d    = win ? i_we1 : i_we0;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = ST_BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d  = win;
`endif
        end
      end
      ST_BUSY: begin
        fin = 1'b1;
        if (i_error_not_present) begin
          err_d = 2'd1;
        end else if (i_error_not_user) begin
          err_d = 2'd2;
        end else if (i_mem_valid) begin
          err_d = 2'd0;
          if (!wr_q) rdata_d = i_mem_data;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          err_d = 2'd3;
        end else begin
          fin  = 1'b0;
          wd_d = wd_q + CW'(1);
        end
        if (fin) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'd0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      wd_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign o_gnt0        = gnt_q[0];
  assign o_gnt1        = gnt_q[1];
  assign o_done0       = done_q[0];
  assign o_done1       = done_q[1];
  assign o_err         = err_q;
  assign o_rdata       = rdata_q;
  assign o_busy        = busy_q;
  assign o_mem_address = addr_q;
  assign o_mem_read    = rd_q;
  assign o_mem_write   = wr_q;
  assign o_mem_data    = wdata_q;

endmodule
